// File: rtl/cnn_frame_driver_pkg.sv
// rtl/cnn_frame_driver_pkg.sv - shared types and constants for the CNN frame driver
package cnn_frame_driver_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FIRE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int PICTURE_SIZE_DEFAULT = 28;
  localparam int NUM_CLASSES          = 11;
  localparam logic [3:0] CLASS_INVALID = 4'hF;

  // Pixels in a square frame of the given edge length
  function automatic int frame_pixels(input int edge_len);
    return edge_len * edge_len;
  endfunction

  localparam int N = frame_pixels(PICTURE_SIZE_DEFAULT);

endpackage

// File: rtl/cnn_frame_driver_frame_watchdog.sv
// rtl/cnn_frame_driver_frame_watchdog.sv - saturating inference timeout counter
module frame_watchdog #(
  parameter int TIMEOUT_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  // Count while enabled; park at all-ones so expiry stays asserted until cleared
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = &cnt;

endmodule

// File: rtl/cnn_frame_driver.sv
// rtl/cnn_frame_driver.sv - streams a frame into the detector database, fires it, returns the class
module cnn_frame_driver
  import cnn_frame_driver_pkg::*;
#(
  parameter int SIZE_1       = 11,
  parameter int PICTURE_SIZE = PICTURE_SIZE_DEFAULT,
  parameter int ADDR_W       = 13,
  parameter int TIMEOUT_W    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [SIZE_1-1:0] s_pixel,
  input  logic                     s_last,
  output logic                     we_database,
  output logic signed [SIZE_1-1:0] dp_database,
  output logic [ADDR_W-1:0]        address_p_database,
  output logic                     GO,
  input  logic                     STOP,
  input  logic [3:0]               RESULT,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_class,
  output logic                     res_err,
  output logic                     busy
);

  localparam int NPIX = frame_pixels(PICTURE_SIZE);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pix_cnt;
  logic               err;
  logic               accept;
  logic               at_last;
  logic               wd_clear, wd_enable, wd_expired;

  assign accept  = s_valid && s_ready;
  assign at_last = (pix_cnt == LAST_IDX);

  frame_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a mismatched s_last/position pair ends the frame as an error
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (accept && (s_last || at_last)) state_nxt = (s_last && at_last) ? ST_FIRE : ST_DONE;
      ST_FIRE: state_nxt = ST_ARM;
      ST_ARM:  if (wd_expired) state_nxt = ST_DONE;
               else if (!STOP) state_nxt = ST_RUN;
      ST_RUN:  if (STOP || wd_expired) state_nxt = ST_DONE;
      ST_DONE: if (res_ready) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  // State-decoded outputs and watchdog controls
  always_comb begin
    s_ready   = (state == ST_LOAD);
    res_valid = (state == ST_DONE);
    busy      = !((state == ST_LOAD) && (pix_cnt == '0));
    wd_clear  = (state == ST_FIRE);
    wd_enable = (state == ST_ARM) || (state == ST_RUN);
  end

  assign res_err = err;

  // Registered write port, GO pulse (one cycle behind FIRE so the last write lands first) and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt            <= '0;
      we_database        <= 1'b0;
      dp_database        <= '0;
      address_p_database <= '0;
      GO                 <= 1'b0;
      res_class          <= CLASS_INVALID;
      err                <= 1'b0;
    end else begin
      we_database <= accept;
      GO          <= (state == ST_FIRE);
      if (accept) begin
        dp_database        <= s_pixel;
        address_p_database <= pix_cnt;
        pix_cnt            <= pix_cnt + 1'b1;
      end
      case (state)
        ST_LOAD: if (accept && (s_last != at_last)) begin
          err       <= 1'b1;
          res_class <= CLASS_INVALID;
        end
        ST_ARM: if (wd_expired) begin
          err       <= 1'b1;
          res_class <= CLASS_INVALID;
        end
        ST_RUN: if (STOP) begin
          err       <= 1'b0;
          res_class <= RESULT;
        end else if (wd_expired) begin
          err       <= 1'b1;
          res_class <= CLASS_INVALID;
        end
        ST_DONE: if (res_ready) pix_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_driver.sv
// tb/tb_cnn_frame_driver.sv - directed self-checking bench for cnn_frame_driver
module tb_cnn_frame_driver;
  import cnn_frame_driver_pkg::*;

  localparam int SIZE_1 = 11;
  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              s_valid, s_ready, s_last, we_database, GO, STOP, res_valid, res_ready, res_err, busy;
  logic [SIZE_1-1:0] s_pixel, dp_database;
  logic [ADDR_W-1:0] address_p_database;
  logic [3:0]        RESULT, res_class;

  logic              t_s_valid, t_s_ready, t_s_last, t_we, t_GO, t_STOP, t_res_valid, t_res_ready, t_res_err, t_busy;
  logic [SIZE_1-1:0] t_s_pixel, t_dp;
  logic [ADDR_W-1:0] t_addr;
  logic [3:0]        t_RESULT, t_res_class;

  cnn_frame_driver dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_last(s_last),
    .we_database(we_database), .dp_database(dp_database), .address_p_database(address_p_database),
    .GO(GO), .STOP(STOP), .RESULT(RESULT), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_err(res_err), .busy(busy)
  );

  cnn_frame_driver #(.PICTURE_SIZE(4), .TIMEOUT_W(8)) dut_t (
    .clk(clk), .rst(rst), .s_valid(t_s_valid), .s_ready(t_s_ready), .s_pixel(t_s_pixel), .s_last(t_s_last),
    .we_database(t_we), .dp_database(t_dp), .address_p_database(t_addr),
    .GO(t_GO), .STOP(t_STOP), .RESULT(t_RESULT), .res_valid(t_res_valid), .res_ready(t_res_ready),
    .res_class(t_res_class), .res_err(t_res_err), .busy(t_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt, wr_bad, go_cnt, go_cyc, go_wide;
  int mul, add;
  logic go_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE_1-1:0] pix_val(input int a);
    return SIZE_1'(a * mul + add);
  endfunction

  // Database write and GO monitor: writes must be contiguous from 0 with the driven pattern
  always @(negedge clk) begin
    if (we_database) begin
      if (address_p_database != ADDR_W'(wr_cnt) || dp_database != pix_val(wr_cnt)) wr_bad++;
      wr_cnt++;
    end
    if (GO) begin
      go_cnt++;
      go_cyc = cyc;
      if (go_prev) go_wide++;
    end
    go_prev = GO;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_we"}, we_database, 0);
    check({tag, "_dp"}, dp_database, 0);
    check({tag, "_addr"}, address_p_database, 0);
    check({tag, "_go"}, GO, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_class"}, res_class, 15);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic drive_frame(input int nbeats, input int last_at, input bit gaps, output int last_c);
    int sent = 0;
    int budget = 0;
    last_c = -1;
    while (sent < nbeats && budget < 10000) begin
      @(negedge clk);
      budget++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_pixel = pix_val(sent);
        s_last  = (sent == last_at);
        if (s_ready) begin
          last_c = cyc;
          sent++;
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("frame_sent", sent, nbeats);
  endtask

  task automatic wait_rv(output int when);
    when = -1;
    for (int b = 0; b < 2000; b++) begin
      @(negedge clk);
      if (res_valid) begin
        when = cyc;
        break;
      end
    end
    check("rv_seen", (when >= 0), 1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("back_s_ready", s_ready, 1);
    check("back_busy", busy, 0);
    check("back_res_valid", res_valid, 0);
  endtask

  // Full frame, GO, STOP handshake and result; optionally reset while in RUN instead of finishing
  task automatic run_nominal(input logic [3:0] result, input bit gaps, input int stall, input bit reset_in_run);
    int g0, last_c, t_stop, t_rv, unstable;
    wr_cnt = 0;
    wr_bad = 0;
    g0 = go_cnt;
    drive_frame(N, N - 1, gaps, last_c);
    for (int b = 0; b < 10 && go_cnt == g0; b++) @(negedge clk);
    check("go_count", go_cnt - g0, 1);
    check("go_latency", go_cyc - last_c, 2);
    check("wr_count", wr_cnt, N);
    check("wr_data", wr_bad, 0);
    STOP = 1'b0;
    if (reset_in_run) begin
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_run");
      rst = 1'b0;
      STOP = 1'b1;
      return;
    end
    repeat (500) @(negedge clk);
    RESULT = result;
    STOP   = 1'b1;
    t_stop = cyc;
    wait_rv(t_rv);
    check("rv_latency", t_rv - t_stop, 1);
    check("res_class", res_class, result);
    check("res_err", res_err, 0);
    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      RESULT = ~result;
      @(negedge clk);
      if (res_class != result || res_err || s_ready || !res_valid) unstable++;
    end
    check("done_stable", unstable, 0);
    release_res();
  endtask

  int lc, t_rv, gt, rt;

  initial begin
    rst = 1'b1;
    s_valid = 0; s_pixel = 0; s_last = 0; STOP = 1'b1; RESULT = 0; res_ready = 0;
    t_s_valid = 0; t_s_pixel = 0; t_s_last = 0; t_STOP = 0; t_RESULT = 0; t_res_ready = 0;
    wr_cnt = 0; wr_bad = 0; go_cnt = 0; go_cyc = 0; go_wide = 0; mul = 1; add = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Timeout, STOP never asserts: resolves 256 cycles after GO; then STOP stuck high from a prior run
    for (int k = 0; k < 2; k++) begin
      t_STOP = (k == 1);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        t_s_valid = 1'b1;
        t_s_pixel = SIZE_1'(i);
        t_s_last  = (i == 15);
      end
      @(negedge clk);
      t_s_valid = 1'b0;
      t_s_last  = 1'b0;
      gt = -1;
      for (int b = 0; b < 20; b++) begin
        if (t_GO) begin
          gt = cyc;
          break;
        end
        @(negedge clk);
      end
      check("to_go_seen", (gt >= 0), 1);
      @(negedge clk);
      check("to_go_width", t_GO, 0);
      rt = -1;
      for (int b = 0; b < 400; b++) begin
        if (t_res_valid) begin
          rt = cyc;
          break;
        end
        @(negedge clk);
      end
      check("to_latency", rt - gt, 256);
      check("to_res_err", t_res_err, 1);
      check("to_res_class", t_res_class, 15);
      t_res_ready = 1'b1;
      @(negedge clk);
      t_res_ready = 1'b0;
      check("to_back_busy", t_busy, 0);
    end

    // Nominal frame, data = address
    run_nominal(4'd7, 1'b0, 2, 1'b0);

    // Short frame: s_last on beat 99
    wr_cnt = 0; wr_bad = 0; lc = go_cnt;
    drive_frame(100, 99, 1'b0, t_rv);
    repeat (3) @(negedge clk);
    check("short_wr_count", wr_cnt, 100);
    check("short_wr_data", wr_bad, 0);
    check("short_no_go", go_cnt - lc, 0);
    check("short_res_valid", res_valid, 1);
    check("short_res_err", res_err, 1);
    check("short_res_class", res_class, 15);
    release_res();

    // Missing last: a full frame with no s_last
    wr_cnt = 0; wr_bad = 0; lc = go_cnt;
    drive_frame(N, -1, 1'b0, t_rv);
    repeat (5) @(negedge clk);
    check("nolast_wr_count", wr_cnt, N);
    check("nolast_wr_data", wr_bad, 0);
    check("nolast_no_go", go_cnt - lc, 0);
    check("nolast_s_ready", s_ready, 0);
    check("nolast_res_err", res_err, 1);
    check("nolast_res_class", res_class, 15);
    release_res();

    // Backpressure with a wrapping signed pattern and a 50-cycle result stall
    mul = 5; add = 900;
    run_nominal(4'd3, 1'b1, 50, 1'b0);

    // Reset mid-inference, then a clean frame
    mul = 3; add = 1;
    run_nominal(4'd0, 1'b0, 0, 1'b1);
    run_nominal(4'd10, 1'b0, 1, 1'b0);

    check("go_single_cycle", go_wide, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
